// File: rtl/mips_mem_wait.sv
// Unified-array memory model for MIPS cores: pipelined fixed-latency fetch port
// plus a data port with wait states, byte enables and error reporting.
module mips_mem_wait #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          IMEM_LAT    = 1,
  parameter int          DMEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        data_be,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              data_err,
  output logic              data_busy
);
  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Port 0 decodes the fetch address, port 1 the data address.
  logic [31:0]   dec_addr [2];
  logic [31:0]   dec_off  [2];
  logic          dec_ok   [2];
  logic [AW-1:0] dec_idx  [2];

  assign dec_addr[0] = inst_addr;
  assign dec_addr[1] = data_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    assign dec_off[gi] = dec_addr[gi] - BASE_ADDR;
    assign dec_ok[gi]  = (dec_addr[gi] >= BASE_ADDR) && (dec_off[gi] < SPAN)
                         && (dec_addr[gi][1:0] == 2'b00);
    assign dec_idx[gi] = dec_off[gi][AW+1:2];
  end

  // Fetch pipeline: stage 0 reads the array, later stages only add delay.
  logic              inst_v_q [IMEM_LAT];
  logic [DATA_W-1:0] inst_d_q [IMEM_LAT];

  for (genvar gi = 0; gi < IMEM_LAT; gi++) begin : g_ipipe
    if (gi == 0) begin : g_rd
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          inst_v_q[gi] <= 1'b0;
          inst_d_q[gi] <= '0;
        end else begin
          inst_v_q[gi] <= inst_req;
          inst_d_q[gi] <= dec_ok[0] ? mem_q[dec_idx[0]] : '0;
        end
      end
    end else begin : g_dly
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          inst_v_q[gi] <= 1'b0;
          inst_d_q[gi] <= '0;
        end else begin
          inst_v_q[gi] <= inst_v_q[gi-1];
          inst_d_q[gi] <= inst_d_q[gi-1];
        end
      end
    end
  end

  assign inst_ready = inst_v_q[IMEM_LAT-1];
  assign inst_rdata = inst_d_q[IMEM_LAT-1];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic              enter_done;
  logic [DATA_W-1:0] data_out_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    err_d      = err_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = dec_idx[1];
          wdata_d = data_in;
          be_d    = data_be;
          rd_d    = mem_read && !mem_write;
          err_d   = !dec_ok[1] || (mem_read && mem_write);
          cnt_d   = 4'(DMEM_LAT - 1);
          if (DMEM_LAT == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The decrement that reaches zero is the one that enters DONE.
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Read data is captured on entry to DONE so it is valid alongside data_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (enter_done) begin
      if (err_d) data_out_q <= '0;
      else if (rd_d) data_out_q <= mem_q[idx_d];
    end
  end

  // Reset forces state_q out of DONE immediately, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == DONE && !rd_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = (state_q == DONE);
  assign data_err   = (state_q == DONE) && err_q;
  assign data_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mips_mem_wait.sv
// Scoreboard bench for mips_mem_wait: drivers queue expected completions, a
// negedge monitor pops and compares data and completion cycle.
module tb_mips_mem_wait;
  localparam int IMEM_LAT = 1;
  localparam int DMEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        mem_read, mem_write;
  logic [31:0] data_addr, data_in, data_out;
  logic [3:0]  data_be;
  logic        data_ready, data_err, data_busy;

  mips_mem_wait #(
    .DATA_W(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000),
    .IMEM_LAT(IMEM_LAT), .DMEM_LAT(DMEM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .data_addr(data_addr), .data_in(data_in), .data_be(data_be),
    .data_out(data_out), .data_ready(data_ready),
    .data_err(data_err), .data_busy(data_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; } iexp_t;
  typedef struct { int cyc; logic err; logic [31:0] out; } dexp_t;

  iexp_t iq[$];
  dexp_t dq[$];
  iexp_t ie_m;
  dexp_t de_m;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_last = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (inst_ready) begin
      if (iq.size() == 0) begin
        chk("inst_unexpected_ready", 32'(inst_ready), 32'h0);
      end else begin
        ie_m = iq.pop_front();
        chk("inst_latency", 32'(cyc), 32'(ie_m.cyc));
        chk("inst_data", inst_rdata, ie_m.data);
        $display("fetch  cyc=%0d data=%h", cyc, inst_rdata);
      end
    end else if (iq.size() > 0 && iq[0].cyc < cyc) begin
      ie_m = iq.pop_front();
      chk("inst_missing_ready", 32'(inst_ready), 32'h1);
    end

    if (data_ready) begin
      if (dq.size() == 0) begin
        chk("data_unexpected_ready", 32'(data_ready), 32'h0);
      end else begin
        de_m = dq.pop_front();
        chk("data_latency", 32'(cyc), 32'(de_m.cyc));
        chk("data_err", 32'(data_err), 32'(de_m.err));
        chk("data_out", data_out, de_m.out);
        $display("data   cyc=%0d err=%0b out=%h", cyc, data_err, data_out);
      end
    end else begin
      if (data_err) chk("data_err_without_ready", 32'(data_err), 32'h0);
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        de_m = dq.pop_front();
        chk("data_missing_ready", 32'(data_ready), 32'h1);
      end
    end
  end

  // Drive a data request for the coming edge and queue its expected completion.
  task automatic issue_data(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            input logic exp_err, input logic [31:0] rval, input bit push);
    dexp_t e;
    mem_read  = rd;
    mem_write = wr;
    data_addr = a;
    data_in   = d;
    data_be   = be;
    if (push) begin
      e.cyc = cyc + DMEM_LAT;
      e.err = exp_err;
      e.out = exp_err ? 32'h0 : (rd ? rval : exp_last);
      exp_last = e.out;
      dq.push_back(e);
    end
  endtask

  task automatic clear_data();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic data_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic exp_err, input logic [31:0] rval);
    issue_data(rd, wr, a, d, be, exp_err, rval, 1'b1);
    @(negedge clk);
    clear_data();
    repeat (DMEM_LAT) @(negedge clk);
  endtask

  task automatic issue_fetch(input logic [31:0] a, input logic [31:0] exp);
    iexp_t e;
    inst_req  = 1'b1;
    inst_addr = a;
    e.cyc  = cyc + IMEM_LAT;
    e.data = exp;
    iq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    mem_read = 1'b0; mem_write = 1'b0;
    data_addr = 32'h0; data_in = 32'h0; data_be = 4'h0;
    #12;
    chk("rst_inst_ready", 32'(inst_ready), 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_data_ready", 32'(data_ready), 32'h0);
    chk("rst_data_err", 32'(data_err), 32'h0);
    chk("rst_data_busy", 32'(data_busy), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Preload words 0..15 with 32'h1111_00ii.
    for (int i = 0; i < 16; i++)
      data_op(1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF, 1'b0, 32'h0);

    // Back-to-back fetches.
    issue_fetch(32'h1000, 32'h1111_0000); @(negedge clk);
    issue_fetch(32'h1004, 32'h1111_0001); @(negedge clk);
    issue_fetch(32'h1008, 32'h1111_0002); @(negedge clk);
    inst_req = 1'b0;
    repeat (2) @(negedge clk);

    // Full-word write then read; byte-lane write; empty-enable write.
    data_op(1'b0, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    data_op(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    data_op(1'b0, 1'b1, 32'h1010, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0);
    data_op(1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
    data_op(1'b0, 1'b1, 32'h1010, 32'h1111_1111, 4'b0000, 1'b0, 32'h0);
    data_op(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEAA);

    // Error accesses: below range, misaligned, read+write together.
    data_op(1'b1, 1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b1, 32'h0);
    data_op(1'b1, 1'b0, 32'h1002, 32'h0, 4'hF, 1'b1, 32'h0);
    data_op(1'b1, 1'b1, 32'h1010, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    data_op(1'b0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    data_op(1'b1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEAA);
    data_op(1'b1, 1'b0, 32'h1FFC, 32'h0, 4'hF, 1'b0, 32'h0);
    issue_fetch(32'h0FFC, 32'h0); @(negedge clk);
    issue_fetch(32'h1002, 32'h0); @(negedge clk);
    issue_fetch(32'h1FFC, 32'h0); @(negedge clk);
    inst_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT aborts a write.
    data_op(1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0, 32'h1111_0001);
    issue_data(1'b0, 1'b1, 32'h1020, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    clear_data();
    chk("busy_in_wait", 32'(data_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_data_busy", 32'(data_busy), 32'h0);
    chk("abort_data_ready", 32'(data_ready), 32'h0);
    chk("abort_data_out", data_out, 32'h0);
    chk("abort_inst_ready", 32'(inst_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_last = 32'h0;
    repeat (2) @(negedge clk);
    data_op(1'b1, 1'b0, 32'h1020, 32'h0, 4'hF, 1'b0, 32'h1111_0008);

    // Write/fetch ordering around the commit edge.
    issue_data(1'b0, 1'b1, 32'h1030, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    clear_data();
    repeat (DMEM_LAT - 1) @(negedge clk);
    issue_fetch(32'h1030, 32'h1111_000C); @(negedge clk);
    issue_fetch(32'h1030, 32'hCAFE_F00D); @(negedge clk);
    inst_req = 1'b0;
    repeat (4) @(negedge clk);

    chk("inst_queue_drained", 32'(iq.size()), 32'h0);
    chk("data_queue_drained", 32'(dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
